// File: rtl/blit_lfu_writer.sv
// Blitter byte sequencer: read source/destination, combine via 4-bit LFU code, write back.
// Optional abort-on-nonzero-destination collision detect is enabled by defining BLIT_COLLISION_EN.
module blit_lfu_writer #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic [3:0]        LFUC,
  input  logic              SRCEN,
  input  logic              DSTEN,
  input  logic              SRC_INC,
  input  logic              DST_INC,
  input  logic [7:0]        PATTERN,
  output logic              BUSY,
  output logic              DONE,
  output logic              MREQ,
  output logic              MWR,
  output logic [ADDR_W-1:0] MADDR,
  output logic [7:0]        MDOUT,
  input  logic [7:0]        MDIN,
  input  logic              MACK,
  output logic              COLLISION
);

  typedef enum logic [2:0] {StIdle, StSrcRd, StDstRd, StWr, StFin} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = 1;
  localparam logic [CNT_W-1:0]  CntOne  = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  rem_q;
  logic [3:0]        lfuc_q;
  logic              srcen_q, dsten_q, src_inc_q, dst_inc_q;
  logic [7:0]        pattern_q, s_q, d_q;

  logic       capture, s_ld, d_ld, step;
  logic [7:0] s_byte, d_byte, result;

  function automatic state_e first_state(input logic se, input logic de);
    if (se)      return StSrcRd;
    else if (de) return StDstRd;
    else         return StWr;
  endfunction

  // Disabled operands come from the captured pattern / constant zero, never from memory.
  assign s_byte = srcen_q ? s_q : pattern_q;
  assign d_byte = dsten_q ? d_q : 8'h00;

  always_comb begin
    result = '0;
    for (int i = 0; i < 8; i++) begin
      result[i] = lfuc_q[{s_byte[i], d_byte[i]}];
    end
  end

`ifdef BLIT_COLLISION_EN
  logic abort;
  logic collision_q;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    s_ld    = 1'b0;
    d_ld    = 1'b0;
    step    = 1'b0;
`ifdef BLIT_COLLISION_EN
    abort   = 1'b0;
`endif
    BUSY    = 1'b0;
    DONE    = 1'b0;
    MREQ    = 1'b0;
    MWR     = 1'b0;
    MADDR   = '0;
    MDOUT   = '0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          capture = 1'b1;
          state_d = first_state(SRCEN, DSTEN);
        end
      end
      StSrcRd: begin
        BUSY  = 1'b1;
        MREQ  = 1'b1;
        MADDR = src_q;
        if (MACK) begin
          s_ld    = 1'b1;
          state_d = dsten_q ? StDstRd : StWr;
        end
      end
      StDstRd: begin
        BUSY  = 1'b1;
        MREQ  = 1'b1;
        MADDR = dst_q;
        if (MACK) begin
          d_ld    = 1'b1;
          state_d = StWr;
`ifdef BLIT_COLLISION_EN
          if (MDIN != 8'h00) begin
            abort   = 1'b1;
            state_d = StFin;
          end
`endif
        end
      end
      StWr: begin
        BUSY  = 1'b1;
        MREQ  = 1'b1;
        MWR   = 1'b1;
        MADDR = dst_q;
        MDOUT = result;
        if (MACK) begin
          step    = 1'b1;
          state_d = (rem_q == CntOne) ? StFin : first_state(srcen_q, dsten_q);
        end
      end
      StFin: begin
        DONE    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      lfuc_q    <= '0;
      srcen_q   <= 1'b0;
      dsten_q   <= 1'b0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      pattern_q <= '0;
      s_q       <= '0;
      d_q       <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        src_q     <= SRC_ADDR;
        dst_q     <= DST_ADDR;
        rem_q     <= COUNT;  // 0 wraps through all 2^CNT_W values before reaching 0 again
        lfuc_q    <= LFUC;
        srcen_q   <= SRCEN;
        dsten_q   <= DSTEN;
        src_inc_q <= SRC_INC;
        dst_inc_q <= DST_INC;
        pattern_q <= PATTERN;
      end
      if (s_ld) s_q <= MDIN;
      if (d_ld) d_q <= MDIN;
      if (step) begin
        if (srcen_q) src_q <= src_inc_q ? src_q + AddrOne : src_q - AddrOne;
        dst_q <= dst_inc_q ? dst_q + AddrOne : dst_q - AddrOne;
        rem_q <= rem_q - CntOne;
      end
    end
  end

`ifdef BLIT_COLLISION_EN
  always_ff @(posedge CLK) begin
    if (RESET)        collision_q <= 1'b0;
    else if (capture) collision_q <= 1'b0;
    else if (abort)   collision_q <= 1'b1;
  end

  assign COLLISION = collision_q;
`else
  assign COLLISION = 1'b0;
`endif

endmodule

// File: tb/tb_blit_lfu_writer.sv
// Directed bench for blit_lfu_writer: LFU truth-table vectors plus multi-cycle run sequences.
module tb_blit_lfu_writer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [19:0] SRC_ADDR = '0;
  logic [19:0] DST_ADDR = '0;
  logic [7:0]  COUNT = '0;
  logic [3:0]  LFUC = '0;
  logic        SRCEN = 1'b0;
  logic        DSTEN = 1'b0;
  logic        SRC_INC = 1'b1;
  logic        DST_INC = 1'b1;
  logic [7:0]  PATTERN = '0;
  logic        BUSY, DONE, MREQ, MWR, COLLISION;
  logic [19:0] MADDR;
  logic [7:0]  MDOUT;
  logic [7:0]  MDIN = '0;
  logic        MACK = 1'b0;

  blit_lfu_writer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR),
    .COUNT(COUNT), .LFUC(LFUC), .SRCEN(SRCEN), .DSTEN(DSTEN), .SRC_INC(SRC_INC),
    .DST_INC(DST_INC), .PATTERN(PATTERN), .BUSY(BUSY), .DONE(DONE), .MREQ(MREQ), .MWR(MWR),
    .MADDR(MADDR), .MDOUT(MDOUT), .MDIN(MDIN), .MACK(MACK), .COLLISION(COLLISION)
  );

  always #5 CLK = ~CLK;

`ifdef BLIT_COLLISION_EN
  localparam int   ColWrites = 1;
  localparam logic ColFlag   = 1'b1;
`else
  localparam int   ColWrites = 4;
  localparam logic ColFlag   = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // Memory responder state
  logic [7:0]  mem [int unsigned];
  logic [19:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  int          max_delay = 0;
  logic        stray_ack = 1'b0;
  int          stab_errs = 0;
  int          delay_left = 0;
  bit          in_xfer = 0;
  logic [19:0] h_addr;
  logic        h_wr;
  logic [7:0]  h_dout;

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return 8'h00;
  endfunction

  always @(negedge CLK) begin
    if (!MREQ) begin
      MACK    = stray_ack;
      MDIN    = 8'h00;
      in_xfer = 0;
    end else begin
      if (!in_xfer) begin
        in_xfer    = 1;
        h_addr     = MADDR;
        h_wr       = MWR;
        h_dout     = MDOUT;
        delay_left = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
      end else if (MADDR !== h_addr || MWR !== h_wr || (MWR && MDOUT !== h_dout)) begin
        stab_errs++;
      end
      if (delay_left == 0) begin
        MACK    = 1'b1;
        MDIN    = MWR ? 8'h00 : mem_rd(MADDR);
        in_xfer = 0;
        if (MWR) begin
          wr_addr.push_back(MADDR);
          wr_data.push_back(MDOUT);
        end
      end else begin
        MACK = 1'b0;
        MDIN = 8'h00;
        delay_left--;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_wr(input string tag, input int k, input logic [19:0] a, input logic [7:0] d);
    logic [19:0] aa;
    logic [7:0]  dd;
    aa = (k < wr_addr.size()) ? wr_addr[k] : 20'hxxxxx;
    dd = (k < wr_data.size()) ? wr_data[k] : 8'hxx;
    check($sformatf("%s_addr%0d", tag, k), 32'(aa), 32'(a));
    check($sformatf("%s_data%0d", tag, k), 32'(dd), 32'(d));
  endtask

  // Starts a run from idle and returns once DONE is seen (or the cycle budget runs out).
  task automatic run_blit(input logic [19:0] src, input logic [19:0] dst, input logic [7:0] cnt,
                          input logic [3:0] lfuc, input logic se, input logic de,
                          input logic si, input logic di, input logic [7:0] pat,
                          output int cycles, output logic busy1);
    @(negedge CLK);
    wr_addr.delete();
    wr_data.delete();
    SRC_ADDR = src; DST_ADDR = dst; COUNT = cnt; LFUC = lfuc;
    SRCEN = se; DSTEN = de; SRC_INC = si; DST_INC = di; PATTERN = pat;
    START = 1'b1;
    @(negedge CLK);
    START  = 1'b0;
    cycles = 1;
    busy1  = BUSY && MREQ;
    while (!DONE && cycles < 2000) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  typedef struct {
    logic [3:0] lfuc;
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int   cyc;
    logic b1;

    vecs[0] = '{4'b0110, 8'h0F, 8'h3C, 8'h33};  // XOR
    vecs[1] = '{4'b1000, 8'hF0, 8'h3C, 8'h30};  // AND
    vecs[2] = '{4'b1110, 8'hF0, 8'h0C, 8'hFC};  // OR
    vecs[3] = '{4'b0001, 8'h0F, 8'h30, 8'hC0};  // NOR
    vecs[4] = '{4'b1010, 8'hFF, 8'h5A, 8'h5A};  // copy D
    vecs[5] = '{4'b0011, 8'h0F, 8'hAA, 8'hF0};  // NOT S
    vecs[6] = '{4'b0100, 8'hFF, 8'h0F, 8'hF0};  // S AND NOT D

    // Reset state
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_mreq", 32'(MREQ), 0);
    check("rst_mwr", 32'(MWR), 0);
    check("rst_maddr", 32'(MADDR), 0);
    check("rst_mdout", 32'(MDOUT), 0);
    check("rst_collision", 32'(COLLISION), 0);
    RESET = 1'b0;

    // Table: single-byte read/read/write runs, MACK immediate
    for (int i = 0; i < 7; i++) begin
      mem[32'h100 + 32'(i)] = vecs[i].s;
      mem[32'h200 + 32'(i)] = vecs[i].d;
      run_blit(20'h00100 + 20'(i), 20'h00200 + 20'(i), 8'd1, vecs[i].lfuc, 1'b1, 1'b1, 1'b1,
               1'b1, 8'h00, cyc, b1);
      check($sformatf("v%0d_busy_first", i), 32'(b1), 1);
      check($sformatf("v%0d_done_cycle", i), 32'(cyc), 4);
      check($sformatf("v%0d_nwr", i), 32'(wr_data.size()), 1);
      check_wr($sformatf("v%0d", i), 0, 20'h00200 + 20'(i), vecs[i].exp);
    end
    @(negedge CLK);
    check("done_one_cycle", 32'(DONE), 0);
    check("idle_busy", 32'(BUSY), 0);

    // Pattern copy, 1 cycle per byte; stray MACK around the run must be ignored
    stray_ack = 1'b1;
    run_blit(20'h0, 20'h00010, 8'd3, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, cyc, b1);
    check("pat_done_cycle", 32'(cyc), 4);
    check("pat_nwr", 32'(wr_data.size()), 3);
    for (int k = 0; k < 3; k++) check_wr("pat", k, 20'h00010 + 20'(k), 8'hA5);
    repeat (2) @(negedge CLK);
    check("stray_ack_mreq", 32'(MREQ), 0);
    check("stray_ack_busy", 32'(BUSY), 0);
    stray_ack = 1'b0;

    // Decrementing destination wraps below zero
    run_blit(20'h0, 20'h00000, 8'd2, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, cyc, b1);
    check("wrap_nwr", 32'(wr_data.size()), 2);
    check_wr("wrap", 0, 20'h00000, 8'h3C);
    check_wr("wrap", 1, 20'hFFFFF, 8'h3C);

    // Random MACK latency, with a START pulse mid-run that must be ignored
    for (int k = 0; k < 6; k++) begin
      mem[32'h300 + 32'(k)] = 8'(8'h03 + 8'(k * 17));
      mem[32'h400 - 32'(k)] = 8'(8'h5A + 8'(k));
    end
    max_delay = 5;
    stab_errs = 0;
    fork
      run_blit(20'h00300, 20'h00400, 8'd6, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, cyc, b1);
      begin
        repeat (6) @(negedge CLK);
        SRC_ADDR = 20'h00700;
        DST_ADDR = 20'h00777;
        START    = 1'b1;
        @(negedge CLK);
        START    = 1'b0;
      end
    join
    check("rand_done", 32'(DONE), 1);
    check("rand_nwr", 32'(wr_data.size()), 6);
    for (int k = 0; k < 6; k++)
      check_wr("rand", k, 20'h00400 - 20'(k),
               mem_rd(20'h00300 + 20'(k)) ^ mem_rd(20'h00400 - 20'(k)));
    check("rand_stability", 32'(stab_errs), 0);
    max_delay = 0;

    // Reset during DST_RD, then a clean run
    @(negedge CLK);
    SRC_ADDR = 20'h00A00; DST_ADDR = 20'h00B00; COUNT = 8'd2; LFUC = 4'b0110;
    SRCEN = 1'b1; DSTEN = 1'b1; SRC_INC = 1'b1; DST_INC = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("mid_dstrd", 32'({MREQ, MWR, MADDR}), 32'({1'b1, 1'b0, 20'h00B00}));
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_outs", 32'({BUSY, DONE, MREQ, MWR, COLLISION}), 0);
    check("mid_rst_bus", 32'({MADDR, MDOUT}), 0);
    RESET = 1'b0;
    mem[32'h800] = 8'h12;
    mem[32'h900] = 8'h34;
    run_blit(20'h00800, 20'h00900, 8'd1, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, cyc, b1);
    check("post_rst_cycle", 32'(cyc), 4);
    check("post_rst_nwr", 32'(wr_data.size()), 1);
    check_wr("post_rst", 0, 20'h00900, 8'h26);

    // Nonzero destination on byte 2
    for (int k = 0; k < 4; k++) begin
      mem[32'h500 + 32'(k)] = 8'(8'h11 * (k + 1));
      mem[32'h600 + 32'(k)] = (k == 1) ? 8'h01 : 8'h00;
    end
    run_blit(20'h00500, 20'h00600, 8'd4, 4'b1100, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, cyc, b1);
    check("col_done", 32'(DONE), 1);
    check("col_flag", 32'(COLLISION), 32'(ColFlag));
    check("col_nwr", 32'(wr_data.size()), 32'(ColWrites));
    for (int k = 0; k < ColWrites; k++)
      check_wr("col", k, 20'h00600 + 20'(k), 8'(8'h11 * (k + 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/blit_lfu_writer.md
# blit_lfu_writer

Blitter inner-loop byte sequencer. Per byte it reads a source byte, optionally reads the destination byte, combines them bitwise through the 4-bit logic function code, and writes the result back to the destination address. It is the memory-side writer that drives the logic function unit's inputs and commits its output. It sits between the blitter register file (program/start) and the system memory arbiter (request/acknowledge).

## Interface
- ADDR_W, 20, memory byte address width
- CNT_W, 8, byte count width
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse; begins a run when idle
- SRC_ADDR  in  ADDR_W  first source address, captured at START
- DST_ADDR  in  ADDR_W  first destination address, captured at START
- COUNT  in  CNT_W  bytes to process; 0 means 2^CNT_W
- LFUC  in  4  logic function code, captured at START
- SRCEN  in  1  1: read source from memory; 0: use PATTERN
- DSTEN  in  1  1: read destination before write; 0: destination byte = 0x00
- SRC_INC, DST_INC  in  1  1: address +1 per byte; 0: address −1
- PATTERN  in  8  source byte when SRCEN=0, captured at START
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse at end of run
- MREQ  out  1  memory request
- MWR  out  1  1 write, 0 read; valid while MREQ
- MADDR  out  ADDR_W  memory address; valid while MREQ
- MDOUT  out  8  write data; valid while MREQ & MWR
- MDIN  in  8  read data; valid in the MACK cycle of a read
- MACK  in  1  transfer complete this cycle
- COLLISION  out  1  sticky collision flag (see Configuration)

## Operation
- States: IDLE, SRC_RD, DST_RD, WR, FIN.
- IDLE: START → capture all inputs; go to SRC_RD if SRCEN, else DST_RD if DSTEN, else WR.
- SRC_RD: MREQ=1, MWR=0, MADDR=src. On MACK, latch MDIN as S; go to DST_RD if DSTEN, else WR.
- DST_RD: MREQ=1, MWR=0, MADDR=dst. On MACK, latch MDIN as D; go to WR.
- WR: MREQ=1, MWR=1, MADDR=dst, MDOUT=result. On MACK: step src (only if SRCEN) and dst by ±1 modulo 2^ADDR_W; decrement remaining. Remaining reaching 0 → FIN, else go to first read state as from IDLE.
- FIN: DONE=1 for one cycle, BUSY=0; go to IDLE.
- Result bit i = LFUC[{S[i],D[i]}]: LFUC[0] for S=0,D=0; LFUC[1] for S=0,D=1; LFUC[2] for S=1,D=0; LFUC[3] for S=1,D=1.
- MADDR, MWR and MDOUT are held stable while MREQ=1 and MACK=0.

## Timing
- Reset values: BUSY 0, DONE 0, MREQ 0, MWR 0, MADDR 0, MDOUT 0, COLLISION 0; state IDLE.
- BUSY and the first MREQ assert in the cycle after START.
- MACK is sampled only while MREQ=1. MACK outside a request, including in IDLE, is ignored.
- Back-to-back transfers: MREQ stays high. The new address, direction and data are presented in the cycle after MACK.
- With MACK tied high: 3 cycles per byte (SRCEN=DSTEN=1); 1 cycle per byte (SRCEN=DSTEN=0).
- DONE is asserted in the cycle after the final write's MACK.
- START while BUSY is ignored.
- RESET mid-run: at the next edge all outputs return to reset values and any pending request is dropped.

## Configuration
- BLIT_COLLISION_EN defined:
  - In DST_RD, a nonzero D aborts the run with no write: COLLISION=1, then FIN.
  - COLLISION clears at the next accepted START.
  - Checked only when DSTEN=1.
- Undefined: COLLISION is constant 0 and runs never abort.

## Test plan
- LFUC=4'b0110 (XOR), SRCEN=DSTEN=1, COUNT=1, S=0x0F, D=0x3C, MACK tied high → writes 0x33 to DST_ADDR; DONE pulses 4 cycles after START.
- SRCEN=0, DSTEN=0, PATTERN=0xA5, LFUC=4'b1100 (copy S), COUNT=3, DST_ADDR=0x00010, DST_INC=1 → writes 0xA5 to 0x00010, 0x00011 and 0x00012 on consecutive cycles.
- DST_ADDR=0x00000, DST_INC=0, COUNT=2 → write addresses 0x00000 then 0xFFFFF (wrap).
- Random MACK delays of 0–5 cycles → MADDR, MWR and MDOUT are stable while MREQ=1 and MACK=0; no transfer is lost or duplicated.
- RESET asserted during DST_RD, then a new START → all outputs are 0 after the reset edge; the new run starts clean with its own captured addresses.
- With BLIT_COLLISION_EN: D=0x01 on byte 2 of COUNT=4 → only byte 1 is written, COLLISION=1, DONE pulses. Without the macro: all 4 bytes are written and COLLISION=0.
